// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS phase-increment sweep sequencer with dwell, loop and abort
module dds_sweep_ctrl #(
    parameter int INC_W   = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [INC_W-1:0]   cfg_start_inc,
    input  logic [INC_W-1:0]   cfg_stop_inc,
    input  logic [INC_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    output logic               dds_we,
    output logic [INC_W-1:0]   dds_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [INC_W-1:0]   start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [INC_W-1:0]   data_q, data_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic               loop_q, loop_d, up_q, up_d;
    logic               we_q, we_d, busy_q, busy_d, done_q, done_d;

    logic [DWELL_W-1:0] dwell_in;
    logic [INC_W:0]     sum, diff;
    logic [INC_W-1:0]   next_inc;
    logic               at_end;

    always_comb begin
        dwell_in = (cfg_dwell == '0) ? '0 : cfg_dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
        sum      = {1'b0, data_q} + {1'b0, step_q};
        diff     = {1'b0, data_q} - {1'b0, step_q};
        // Carry/borrow out of the top bit means the step wrapped; clamp like an overshoot.
        if (up_q)
            next_inc = (sum[INC_W] || sum[INC_W-1:0] > stop_q) ? stop_q : sum[INC_W-1:0];
        else
            next_inc = (diff[INC_W] || diff[INC_W-1:0] < stop_q) ? stop_q : diff[INC_W-1:0];
        // A zero step can never reach stop, so it ends after its single value.
        at_end = (data_q == stop_q) || (step_q == '0);
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        up_d    = up_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    start_d = cfg_start_inc;
                    stop_d  = cfg_stop_inc;
                    step_d  = cfg_step;
                    dwell_d = dwell_in;
                    loop_d  = cfg_loop;
                    up_d    = (cfg_stop_inc >= cfg_start_inc);
                    data_d  = cfg_start_inc;
                    cnt_d   = dwell_in;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else if (!at_end) begin
                    data_d = next_inc;
                    we_d   = 1'b1;
                    cnt_d  = dwell_q;
                end else if (loop_q) begin
                    data_d = start_q;
                    we_d   = 1'b1;
                    cnt_d  = dwell_q;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            up_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            up_q    <= up_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dds_we   = we_q;
    assign dds_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - scoreboard bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_start_inc = '0;
    logic [15:0] cfg_stop_inc = '0;
    logic [15:0] cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_loop = 1'b0;
    logic        dds_we;
    logic [15:0] dds_data;
    logic        busy;
    logic        done;

    dds_sweep_ctrl #(.INC_W(16), .DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
        .dds_we(dds_we), .dds_data(dds_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic exp_w(input logic [15:0] d, input int c);
        q.push_back('{is_done: 1'b0, data: d, cyc: c});
    endtask

    task automatic exp_done(input logic [15:0] d, input int c);
        q.push_back('{is_done: 1'b1, data: d, cyc: c});
    endtask

    // Monitor: every strobe or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (dds_we || done)) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: we=%0b done=%0b data=0x%0h at cycle %0d, required no event",
                         dds_we, done, dds_data, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind_done", done, e.is_done);
                chk("event_we", dds_we, !e.is_done);
                chk("event_data", dds_data, e.data);
                chk("event_cycle", cyc, e.cyc);
                chk("event_busy", busy, !e.is_done);
            end
        end
    end

    task automatic launch(input logic [15:0] s, input logic [15:0] p, input logic [15:0] st,
                          input logic [15:0] dw, input logic lp);
        @(negedge clk);
        cfg_start_inc = s;
        cfg_stop_inc  = p;
        cfg_step      = st;
        cfg_dwell     = dw;
        cfg_loop      = lp;
        start         = 1'b1;
        c0            = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_we", dds_we, 0);
        chk("reset_data", dds_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        // Up sweep, with a cfg change and start pulse mid-sweep that must be ignored
        launch(16'h0100, 16'h0400, 16'h0100, 16'd4, 1'b0);
        exp_w(16'h0100, c0 + 1);
        exp_w(16'h0200, c0 + 5);
        exp_w(16'h0300, c0 + 9);
        exp_w(16'h0400, c0 + 13);
        exp_done(16'h0400, c0 + 17);
        chk("up_busy_first", busy, 1);
        wait_cyc(c0 + 3);
        cfg_stop_inc = 16'h0200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 16);
        chk("up_busy_last", busy, 1);
        @(negedge clk);
        chk("up_busy_end", busy, 0);
        drain("up_drain");

        // Down sweep landing on stop
        launch(16'h0400, 16'h0100, 16'h0180, 16'd2, 1'b0);
        exp_w(16'h0400, c0 + 1);
        exp_w(16'h0280, c0 + 3);
        exp_w(16'h0100, c0 + 5);
        exp_done(16'h0100, c0 + 7);
        drain("down_drain");
        chk("down_data_hold", dds_data, 16'h0100);

        // Overflow clamp, dwell 0 behaves as 1
        launch(16'hFF00, 16'hFFFF, 16'h0080, 16'd0, 1'b0);
        exp_w(16'hFF00, c0 + 1);
        exp_w(16'hFF80, c0 + 2);
        exp_w(16'hFFFF, c0 + 3);
        exp_done(16'hFFFF, c0 + 4);
        drain("ovf_drain");
        chk("ovf_data_hold", dds_data, 16'hFFFF);

        // Loop then abort mid-dwell
        launch(16'h0010, 16'h0030, 16'h0010, 16'd3, 1'b1);
        exp_w(16'h0010, c0 + 1);
        exp_w(16'h0020, c0 + 4);
        exp_w(16'h0030, c0 + 7);
        exp_w(16'h0010, c0 + 10);
        exp_w(16'h0020, c0 + 13);
        wait_cyc(c0 + 14);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_we", dds_we, 0);
        chk("abort_data", dds_data, 16'h0020);
        drain("abort_drain");
        chk("abort_data_hold", dds_data, 16'h0020);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("sa_busy_later", busy, 0);
        drain("sa_drain");

        // Async reset mid-sweep, then a clean sweep
        launch(16'h0100, 16'h0400, 16'h0100, 16'd4, 1'b0);
        exp_w(16'h0100, c0 + 1);
        exp_w(16'h0200, c0 + 5);
        wait_cyc(c0 + 6);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", dds_data, 0);
        chk("arst_we", dds_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_queue", q.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        launch(16'h0100, 16'h0400, 16'h0100, 16'd4, 1'b0);
        exp_w(16'h0100, c0 + 1);
        exp_w(16'h0200, c0 + 5);
        exp_w(16'h0300, c0 + 9);
        exp_w(16'h0400, c0 + 13);
        exp_done(16'h0400, c0 + 17);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
